// File: rtl/multicycle_computer.sv
// multicycle_computer: multi-cycle 16-bit-instruction processor with a 16-entry
// register file, ALU and NZCV flags. Instruction and data memory are reached
// through req/ack ports, so memories with wait states are supported.
//
// Ports:
//   clk, reset_n             clock (rising edge), synchronous active-low reset
//   imem_addr/req/ack/rdata  instruction fetch port (addr = PC)
//   dmem_addr/req/we/wdata   data port request side, held stable until ack
//   dmem_ack/rdata           data port response (rdata valid on ack for loads)
//   flags                    {N,Z,C,V}
//   halted                   high once HALT has executed
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | imem_req high until imem_ack; IR latched on ack
// DECODE | register operands rn, rm, rd latched
// EXEC   | ALU op, flag update, PC <= branch target or PC+1
// MEM    | dmem_req high with addr/we/wdata stable until dmem_ack
// WB     | result (ALU or load data) written to rd
// HALT   | terminal, no requests; left only through reset
module multicycle_computer #(
  parameter int DATA_W = 8,
  parameter int NREG = 16,
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [DATA_W-1:0] dmem_addr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [3:0]        flags,
  output logic              halted
);

  localparam int M = DATA_W - 1;

  localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_ORR = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4, OP_LSL = 4'h5, OP_LSR = 4'h6, OP_LDR = 4'h7;
  localparam logic [3:0] OP_STR  = 4'h8, OP_B   = 4'h9, OP_BEQ = 4'hA, OP_BNE = 4'hB;
  localparam logic [3:0] OP_CMP  = 4'hC, OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state, next_state;

  logic [PC_W-1:0]   pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] op_a, op_b, op_d, res_q;
  // Always 16 entries; entries at index >= NREG are never written, so they
  // stay at their reset value of 0 and reads of them return 0.
  logic [DATA_W-1:0] rf [16];

  logic [3:0] op, rd, rn, rm;
  assign op = ir[15:12];
  assign rd = ir[11:8];
  assign rn = ir[7:4];
  assign rm = ir[3:0];

  assign imem_addr = pc;
  assign halted    = (state == S_HALT);

  logic [DATA_W-1:0] imm_z, add_b, alu_res;
  logic [DATA_W:0]   sum_add, sum_sub;
  logic [3:0]        alu_flags;
  logic              shift_big, taken;
  logic [PC_W-1:0]   pc_inc, br_off, br_target;

  always_comb begin
    imm_z     = DATA_W'(ir[3:0]);
    add_b     = (op == OP_ADDI) ? imm_z : op_b;
    sum_add   = {1'b0, op_a} + {1'b0, add_b};
    // Carry out of a + ~b + 1 is the no-borrow flag.
    sum_sub   = {1'b0, op_a} + {1'b0, ~op_b} + (DATA_W+1)'(1);
    shift_big = ({28'd0, ir[3:0]} >= 32'(DATA_W));
    alu_res   = '0;
    alu_flags = flags;
    case (op)
      OP_ADD, OP_ADDI: begin
        alu_res   = sum_add[M:0];
        alu_flags = {sum_add[M], ~|sum_add[M:0], sum_add[DATA_W],
                     (op_a[M] == add_b[M]) && (sum_add[M] != op_a[M])};
      end
      OP_SUB, OP_CMP: begin
        alu_res   = sum_sub[M:0];
        alu_flags = {sum_sub[M], ~|sum_sub[M:0], sum_sub[DATA_W],
                     (op_a[M] != op_b[M]) && (sum_sub[M] != op_a[M])};
      end
      OP_AND: begin
        alu_res   = op_a & op_b;
        alu_flags = {alu_res[M], ~|alu_res, flags[1:0]};
      end
      OP_ORR: begin
        alu_res   = op_a | op_b;
        alu_flags = {alu_res[M], ~|alu_res, flags[1:0]};
      end
      OP_LSL: begin
        alu_res   = shift_big ? '0 : (op_a << ir[3:0]);
        alu_flags = {alu_res[M], ~|alu_res, flags[1:0]};
      end
      OP_LSR: begin
        alu_res   = shift_big ? '0 : (op_a >> ir[3:0]);
        alu_flags = {alu_res[M], ~|alu_res, flags[1:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_inc    = pc + PC_W'(1);
    br_off    = PC_W'($signed(ir[7:0]));
    br_target = pc_inc + br_off;
    taken     = (op == OP_B) || ((op == OP_BEQ) && flags[2]) ||
                ((op == OP_BNE) && !flags[2]);
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (imem_req && imem_ack) next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_LDR, OP_STR: next_state = S_MEM;
          OP_ADD, OP_SUB, OP_AND, OP_ORR,
          OP_ADDI, OP_LSL, OP_LSR: next_state = S_WB;
          OP_HLT:         next_state = S_HALT;
          default:        next_state = S_FETCH;
        endcase
      end
      S_MEM:    if (dmem_req && dmem_ack) next_state = (op == OP_LDR) ? S_WB : S_FETCH;
      S_WB:     next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  // Requests are flops loaded from next_state: ack never reaches req
  // combinationally, and req is already high in the first cycle of FETCH/MEM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_d       <= '0;
      res_q      <= '0;
      flags      <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      state    <= next_state;
      imem_req <= (next_state == S_FETCH);
      dmem_req <= (next_state == S_MEM);
      case (state)
        S_FETCH: if (imem_req && imem_ack) ir <= imem_rdata;
        S_DECODE: begin
          op_a <= rf[rn];
          op_b <= rf[rm];
          op_d <= rf[rd];
        end
        S_EXEC: begin
          pc         <= taken ? br_target : pc_inc;
          flags      <= alu_flags;
          res_q      <= alu_res;
          dmem_addr  <= op_a + imm_z;
          dmem_we    <= (op == OP_STR);
          dmem_wdata <= op_d;
        end
        S_MEM: begin
          if (dmem_req && dmem_ack) begin
            res_q   <= dmem_rdata;
            dmem_we <= 1'b0;
          end
        end
        S_WB: if ({28'd0, rd} < 32'(NREG)) rf[rd] <= res_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_computer.sv
// tb_multicycle_computer: directed programs against multicycle_computer with
// behavioural instruction/data memories that insert programmable wait states.
module tb_multicycle_computer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_req, imem_ack;
  logic [15:0] imem_rdata;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [3:0]  flags;
  logic        halted;

  multicycle_computer dut (
    .clk(clk), .reset_n(reset_n),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .flags(flags), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  logic dmem_clear = 1'b0, mon_clr = 1'b0;

  assign imem_ack   = imem_req && (icnt == iwait);
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt == dwait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_clear) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'hAA;
    end else if (dmem_req && dmem_ack && dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
    end
  end

  // Fetch log: cycle, address and flags seen at each completed fetch.
  int         cyc = 0, nfetch = 0, we4 = 0;
  int         fcyc [64];
  logic [7:0] faddr [64];
  logic [3:0] fflags [64];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      nfetch <= 0;
      we4    <= 0;
    end else begin
      if (imem_req && imem_ack && nfetch < 64) begin
        fcyc[nfetch]   <= cyc;
        faddr[nfetch]  <= imem_addr;
        fflags[nfetch] <= flags;
        nfetch         <= nfetch + 1;
      end
      if (dmem_req && dmem_we && dmem_addr == 8'd4) we4 <= we4 + 1;
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    mon_clr    = 1'b1;
    dmem_clear = 1'b1;
    tick();
    tick();
    reset_n    = 1'b1;
    mon_clr    = 1'b0;
    dmem_clear = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int k = 0;
    while (!halted && k < budget) begin
      tick();
      k++;
    end
    chk(tag, halted, 1);
  endtask

  task automatic wait_fetch(input int n, input int budget);
    int k = 0;
    while (nfetch < n && k < budget) begin
      tick();
      k++;
    end
    if (nfetch < n) chk("fetch_timeout", nfetch, n);
  endtask

  initial begin
    int q;
    int k;

    // Test 1: ADDI, ADDI, SUB; reset state checked while reset is held.
    clr_imem();
    imem[0] = 16'h4105;  // ADDI r1,r0,5
    imem[1] = 16'h4203;  // ADDI r2,r0,3
    imem[2] = 16'h1312;  // SUB  r3,r1,r2
    imem[3] = 16'h8300;  // STR  r3,[r0+0]
    reset_n = 1'b0;
    mon_clr = 1'b1;
    dmem_clear = 1'b1;
    tick();
    tick();
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_pc", imem_addr, 0);
    chk("rst_flags", flags, 0);
    chk("rst_halted", halted, 0);
    reset_n = 1'b1;
    mon_clr = 1'b0;
    dmem_clear = 1'b0;
    wait_halt("t1_halt", 200);
    chk("t1_r3", dmem[0], 8'h02);
    chk("t1_flags", flags, 4'b0010);
    chk("t1_lat_addi", fcyc[1] - fcyc[0], 4);
    chk("t1_lat_sub", fcyc[3] - fcyc[2], 4);
    chk("t1_lat_str", fcyc[4] - fcyc[3], 4);
    chk("t1_pc", imem_addr, 8'd5);

    // Test 2: signed overflow on ADD, then CMP borrow.
    clr_imem();
    imem[0] = 16'h410F;  // ADDI r1,r0,15
    imem[1] = 16'h5113;  // LSL  r1,r1,3  -> 0x78
    imem[2] = 16'h4117;  // ADDI r1,r1,7  -> 0x7F
    imem[3] = 16'h4201;  // ADDI r2,r0,1
    imem[4] = 16'h0312;  // ADD  r3,r1,r2 -> 0x80
    imem[5] = 16'h8300;  // STR  r3,[r0+0]
    imem[6] = 16'hC021;  // CMP  r2,r1
    do_reset();
    wait_halt("t2_halt", 200);
    chk("t2_add", dmem[0], 8'h80);
    chk("t2_add_flags", fflags[5], 4'b1001);
    chk("t2_addi_flags", fflags[3], 4'b0000);
    chk("t2_cmp_flags", flags, 4'b1000);

    // Test 2b: logic ops, shifts (including shift >= width) and r15.
    clr_imem();
    imem[0]  = 16'h410C;  // ADDI r1,r0,12
    imem[1]  = 16'h420A;  // ADDI r2,r0,10
    imem[2]  = 16'h2312;  // AND  r3,r1,r2
    imem[3]  = 16'h3412;  // ORR  r4,r1,r2
    imem[4]  = 16'h6512;  // LSR  r5,r1,2
    imem[5]  = 16'h5618;  // LSL  r6,r1,8
    imem[6]  = 16'h8301;
    imem[7]  = 16'h8402;
    imem[8]  = 16'h8503;
    imem[9]  = 16'h8604;
    imem[10] = 16'h4F09;  // ADDI r15,r0,9
    imem[11] = 16'h8F08;
    do_reset();
    wait_halt("t2b_halt", 300);
    chk("t2b_and", dmem[1], 8'h08);
    chk("t2b_orr", dmem[2], 8'h0E);
    chk("t2b_lsr", dmem[3], 8'h03);
    chk("t2b_lsl_big", dmem[4], 8'h00);
    chk("t2b_lsl_flags", fflags[6], 4'b0100);
    chk("t2b_r15", dmem[8], 8'h09);

    // Test 3: store/load with 2 data wait states.
    clr_imem();
    imem[0] = 16'h4309;  // ADDI r3,r0,9
    imem[1] = 16'h8304;  // STR  r3,[r0+4]
    imem[2] = 16'h7404;  // LDR  r4,[r0+4]
    imem[3] = 16'h8405;  // STR  r4,[r0+5]
    dwait = 2;
    do_reset();
    wait_halt("t3_halt", 300);
    chk("t3_we_cycles", we4, 3);
    chk("t3_ldr", dmem[5], 8'h09);
    chk("t3_lat_str", fcyc[2] - fcyc[1], 6);
    chk("t3_lat_ldr", fcyc[3] - fcyc[2], 7);
    dwait = 0;

    // Test 4: CMP, BEQ taken, BNE not taken, unconditional B.
    clr_imem();
    imem[0] = 16'h4101;  // ADDI r1,r0,1
    imem[1] = 16'hC011;  // CMP  r1,r1
    imem[2] = 16'hA002;  // BEQ  +2 -> 5
    imem[3] = 16'h4701;
    imem[4] = 16'h4702;
    imem[5] = 16'hB002;  // BNE  +2, not taken
    imem[6] = 16'h8706;  // STR  r7,[r0+6]
    imem[7] = 16'h9001;  // B    +1 -> 9
    imem[8] = 16'h4F0F;
    do_reset();
    wait_halt("t4_halt", 300);
    chk("t4_cmp_flags", fflags[2], 4'b0110);
    chk("t4_beq_target", faddr[3], 8'd5);
    chk("t4_bne_next", faddr[4], 8'd6);
    chk("t4_b_target", faddr[6], 8'd9);
    chk("t4_lat_cmp", fcyc[2] - fcyc[1], 3);
    chk("t4_lat_beq", fcyc[3] - fcyc[2], 3);
    chk("t4_lat_bne", fcyc[4] - fcyc[3], 3);
    chk("t4_skipped", dmem[6], 8'h00);
    chk("t4_pc", imem_addr, 8'd10);

    // Test 5: NOPs then HALT at PC=6, bus stays quiet.
    clr_imem();
    for (int i = 0; i < 6; i++) imem[i] = 16'hD000;
    do_reset();
    wait_halt("t5_halt", 200);
    q = 0;
    repeat (20) begin
      tick();
      if (imem_req || dmem_req) q++;
    end
    chk("t5_quiet", q, 0);
    chk("t5_pc", imem_addr, 8'd7);
    chk("t5_lat_nop", fcyc[1] - fcyc[0], 3);

    // Test 6: reset during a 3-wait-state fetch.
    clr_imem();
    imem[0] = 16'h8307;  // STR  r3,[r0+7]
    imem[1] = 16'h430C;  // ADDI r3,r0,12
    imem[2] = 16'h5334;  // LSL  r3,r3,4 -> 0xC0
    imem[3] = 16'h90FC;  // B    -4 -> 0
    iwait = 3;
    do_reset();
    wait_fetch(7, 600);
    k = 0;
    while (!imem_req && k < 50) begin
      tick();
      k++;
    end
    chk("t6_in_fetch", imem_req, 1);
    chk("t6_pre_store", dmem[7], 8'hC0);
    chk("t6_pre_flags", flags, 4'b1000);
    reset_n = 1'b0;
    mon_clr = 1'b1;
    tick();
    chk("t6_req_drop", imem_req, 0);
    chk("t6_pc", imem_addr, 8'd0);
    chk("t6_flags", flags, 0);
    chk("t6_halted", halted, 0);
    tick();
    reset_n = 1'b1;
    mon_clr = 1'b0;
    wait_fetch(2, 200);
    chk("t6_restart_addr", faddr[0], 8'd0);
    chk("t6_regs_zero", dmem[7], 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
